// File: rtl/seq_alu_if.sv
// Request/result handshake bundle for seq_alu: one valid/ready pair for requests, one for results.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic             o_ready;
  logic [4:0]       i_alu_op;
  logic [WIDTH-1:0] i_operand_a;
  logic [WIDTH-1:0] i_operand_b;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_alu_data;

  modport master (
    output i_valid, i_alu_op, i_operand_a, i_operand_b, i_ready,
    input  o_ready, o_valid, o_alu_data
  );

  modport slave (
    input  i_valid, i_alu_op, i_operand_a, i_operand_b, i_ready,
    output o_ready, o_valid, o_alu_data
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with valid/ready request and result handshakes.
// Define SEQ_ALU_MDU_EN to add the radix-2 iterative multiply/divide unit (op codes 16-23).
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic     i_clk,
  input  logic     i_rst,
  seq_alu_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_SLT  = 5'd2;
  localparam logic [4:0] OP_SLTU = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_OR   = 5'd5;
  localparam logic [4:0] OP_AND  = 5'd6;
  localparam logic [4:0] OP_SLL  = 5'd7;
  localparam logic [4:0] OP_SRL  = 5'd8;
  localparam logic [4:0] OP_SRA  = 5'd9;

`ifdef SEQ_ALU_MDU_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

  state_t           state;
  logic             ready;
  logic             valid;
  logic [WIDTH-1:0] result;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] base_result;

  assign a     = bus.i_operand_a;
  assign b     = bus.i_operand_b;
  assign shamt = b[SHW-1:0];

  // Single-cycle ops are evaluated straight from the request; unsupported codes fall to zero.
  always_comb begin
    base_result = '0;
    case (bus.i_alu_op)
      OP_ADD:  base_result = a + b;
      OP_SUB:  base_result = a - b;
      OP_SLT:  base_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: base_result = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_XOR:  base_result = a ^ b;
      OP_OR:   base_result = a | b;
      OP_AND:  base_result = a & b;
      OP_SLL:  base_result = a << shamt;
      OP_SRL:  base_result = a >> shamt;
      OP_SRA:  base_result = $signed(a) >>> shamt;
      default: base_result = '0;
    endcase
  end

`ifdef SEQ_ALU_MDU_EN
  localparam logic [4:0] OP_MUL    = 5'd16;
  localparam logic [4:0] OP_MULH   = 5'd17;
  localparam logic [4:0] OP_MULHSU = 5'd18;
  localparam logic [4:0] OP_MULHU  = 5'd19;
  localparam logic [4:0] OP_DIV    = 5'd20;
  localparam logic [4:0] OP_DIVU   = 5'd21;
  localparam logic [4:0] OP_REM    = 5'd22;
  localparam logic [4:0] OP_REMU   = 5'd23;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   dividend;
  logic [4:0]         op_q;
  logic [CW-1:0]      count;
  logic               neg;
  logic               rem_neg;
  logic               div_zero;

  logic               is_mdu;
  logic               a_sign;
  logic               b_sign;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   mdu_result;

  assign is_mdu = (bus.i_alu_op[4:3] == 2'b10);

  // The core works on magnitudes; only operands treated as signed by the op contribute a sign.
  always_comb begin
    a_sign = 1'b0;
    b_sign = 1'b0;
    case (bus.i_alu_op)
      OP_MULH, OP_DIV, OP_REM: begin
        a_sign = a[WIDTH-1];
        b_sign = b[WIDTH-1];
      end
      OP_MULHSU: a_sign = a[WIDTH-1];
      default: ;
    endcase
  end

  assign abs_a = a_sign ? -a : a;
  assign abs_b = b_sign ? -b : b;

  // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for restoring divide.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    if (op_q[2]) begin
      if (!div_diff[WIDTH])
        acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_step = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  assign product = neg ? -acc_step : acc_step;
  assign quo     = neg ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
  assign rem     = rem_neg ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];

  // Signed overflow needs no special case: the magnitude path already yields most-negative and zero.
  always_comb begin
    mdu_result = '0;
    case (op_q)
      OP_MUL:                       mdu_result = product[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: mdu_result = product[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              mdu_result = div_zero ? '1 : quo;
      OP_REM, OP_REMU:              mdu_result = div_zero ? dividend : rem;
      default:                      mdu_result = '0;
    endcase
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      ready  <= 1'b1;
      valid  <= 1'b0;
      result <= '0;
`ifdef SEQ_ALU_MDU_EN
      acc      <= '0;
      opnd     <= '0;
      dividend <= '0;
      op_q     <= '0;
      count    <= '0;
      neg      <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_valid) begin
            ready  <= 1'b0;
            state  <= DONE;
            valid  <= 1'b1;
            result <= base_result;
`ifdef SEQ_ALU_MDU_EN
            if (is_mdu) begin
              state    <= BUSY;
              valid    <= 1'b0;
              op_q     <= bus.i_alu_op;
              count    <= '0;
              neg      <= a_sign ^ b_sign;
              rem_neg  <= a_sign;
              dividend <= a;
              div_zero <= (b == '0);
              if (bus.i_alu_op[2]) begin
                acc  <= {{WIDTH{1'b0}}, abs_a};
                opnd <= abs_b;
              end else begin
                acc  <= {{WIDTH{1'b0}}, abs_b};
                opnd <= abs_a;
              end
            end
`endif
          end
        end
`ifdef SEQ_ALU_MDU_EN
        BUSY: begin
          acc   <= acc_step;
          count <= count + 1'b1;
          if (count == CW'(WIDTH-1)) begin
            state  <= DONE;
            valid  <= 1'b1;
            result <= mdu_result;
          end
        end
`endif
        DONE: begin
          if (bus.i_ready) begin
            state <= IDLE;
            valid <= 1'b0;
            ready <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.o_ready    = ready;
  assign bus.o_valid    = valid;
  assign bus.o_alu_data = result;
endmodule

// File: tb/tb_seq_alu.sv
// Directed scoreboard bench for seq_alu; expectations follow SEQ_ALU_MDU_EN when it is defined.
module tb_seq_alu;
  localparam int WIDTH = 32;
`ifdef SEQ_ALU_MDU_EN
  localparam bit MDU     = 1'b1;
  localparam int MDU_LAT = WIDTH + 1;
`else
  localparam bit MDU     = 1'b0;
  localparam int MDU_LAT = 1;
`endif

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLT = 5'd2,  OP_SLTU = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4,  OP_OR = 5'd5,   OP_AND = 5'd6,  OP_SLL = 5'd7;
  localparam logic [4:0] OP_SRL = 5'd8,  OP_SRA = 5'd9;
  localparam logic [4:0] OP_MUL = 5'd16, OP_MULH = 5'd17, OP_MULHSU = 5'd18, OP_MULHU = 5'd19;
  localparam logic [4:0] OP_DIV = 5'd20, OP_DIVU = 5'd21, OP_REM = 5'd22,    OP_REMU = 5'd23;

  typedef struct {
    string       tag;
    logic [31:0] data;
    int          lat;
    int          accept;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  exp_t sb[$];

  seq_alu_if #(.WIDTH(WIDTH)) bus();

  seq_alu #(.WIDTH(WIDTH)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cycle <= cycle + 1;

  function automatic logic [31:0] mduExp(input logic [31:0] value);
    return MDU ? value : 32'h0;
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Waits for o_ready, drives one request, and records the expected result once it is accepted.
  task automatic applyStimulus(input string tag, input logic [4:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_data, input int exp_lat);
    int   waited = 0;
    exp_t e;
    @(negedge i_clk);
    while (!bus.o_ready && waited < 100) begin
      @(negedge i_clk);
      waited++;
    end
    checkValue({tag, "_ready"}, 32'(bus.o_ready), 32'd1);
    bus.i_valid     = 1'b1;
    bus.i_alu_op    = op;
    bus.i_operand_a = a;
    bus.i_operand_b = b;
    @(posedge i_clk);
    #1;
    bus.i_valid = 1'b0;
    e.tag    = tag;
    e.data   = exp_data;
    e.lat    = exp_lat;
    e.accept = cycle;
    sb.push_back(e);
  endtask

  // Pops the oldest expectation when a result appears; optionally stalls i_ready while poking i_valid.
  task automatic checkOutput(input int hold);
    int   waited = 0;
    exp_t e;
    @(negedge i_clk);
    while (!bus.o_valid && waited < 200) begin
      @(negedge i_clk);
      waited++;
    end
    if (sb.size() == 0) begin
      checkValue("scoreboard_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    checkValue({e.tag, "_valid"}, 32'(bus.o_valid), 32'd1);
    checkValue({e.tag, "_data"}, bus.o_alu_data, e.data);
    checkValue({e.tag, "_latency"}, 32'(cycle - e.accept + 1), 32'(e.lat));
    for (int i = 0; i < hold; i++) begin
      bus.i_valid     = i[0];
      bus.i_alu_op    = OP_SUB;
      bus.i_operand_a = $urandom;
      bus.i_operand_b = $urandom;
      @(posedge i_clk);
      #1;
      bus.i_valid = 1'b0;
      @(negedge i_clk);
      checkValue({e.tag, "_hold_valid"}, 32'(bus.o_valid), 32'd1);
      checkValue({e.tag, "_hold_data"}, bus.o_alu_data, e.data);
      checkValue({e.tag, "_hold_ready"}, 32'(bus.o_ready), 32'd0);
    end
    bus.i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    bus.i_ready = 1'b0;
    @(negedge i_clk);
    checkValue({e.tag, "_release_ready"}, 32'(bus.o_ready), 32'd1);
    checkValue({e.tag, "_release_valid"}, 32'(bus.o_valid), 32'd0);
  endtask

  initial begin
    int waited;
    int seen;
    bus.i_valid     = 1'b0;
    bus.i_ready     = 1'b0;
    bus.i_alu_op    = '0;
    bus.i_operand_a = '0;
    bus.i_operand_b = '0;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    checkValue("reset_ready", 32'(bus.o_ready), 32'd1);
    checkValue("reset_valid", 32'(bus.o_valid), 32'd0);
    checkValue("reset_data", bus.o_alu_data, 32'h0);

    applyStimulus("add_wrap", OP_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1);        checkOutput(0);
    applyStimulus("sub_wrap", OP_SUB, 32'h0, 32'h1, 32'hFFFFFFFF, 1);               checkOutput(0);
    applyStimulus("slt", OP_SLT, 32'hFFFFFFFF, 32'h1, 32'h1, 1);                    checkOutput(0);
    applyStimulus("sltu", OP_SLTU, 32'hFFFFFFFF, 32'h1, 32'h0, 1);                  checkOutput(0);
    applyStimulus("xor", OP_XOR, 32'hF0F0A5A5, 32'h0FF0FFFF, 32'hFF005A5A, 1);      checkOutput(0);
    applyStimulus("or", OP_OR, 32'hF0F00000, 32'h000F0F0F, 32'hF0FF0F0F, 1);        checkOutput(0);
    applyStimulus("and", OP_AND, 32'hF0F0A5A5, 32'h0FF0FFFF, 32'h00F0A5A5, 1);      checkOutput(0);
    applyStimulus("sll", OP_SLL, 32'h1, 32'h21, 32'h2, 1);                          checkOutput(0);
    applyStimulus("srl", OP_SRL, 32'h80000000, 32'h4, 32'h08000000, 1);             checkOutput(0);
    applyStimulus("sra", OP_SRA, 32'h80000000, 32'h24, 32'hF8000000, 1);            checkOutput(0);
    applyStimulus("sra_pos", OP_SRA, 32'h40000000, 32'h1F, 32'h0, 1);               checkOutput(0);
    applyStimulus("unsup10", 5'd10, 32'h5, 32'h6, 32'h0, 1);                        checkOutput(0);
    applyStimulus("unsup31", 5'd31, 32'hFFFFFFFF, 32'h1, 32'h0, 1);                 checkOutput(0);

    applyStimulus("mul", OP_MUL, 32'h3, 32'h4, mduExp(32'hC), MDU_LAT);                       checkOutput(0);
    applyStimulus("mul_neg", OP_MUL, 32'hFFFFFFFD, 32'h5, mduExp(32'hFFFFFFF1), MDU_LAT);     checkOutput(0);
    applyStimulus("mulh", OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, mduExp(32'h0), MDU_LAT);       checkOutput(0);
    applyStimulus("mulh_big", OP_MULH, 32'h80000000, 32'h80000000, mduExp(32'h40000000), MDU_LAT); checkOutput(0);
    applyStimulus("mulhu", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, mduExp(32'hFFFFFFFE), MDU_LAT);   checkOutput(0);
    applyStimulus("mulhsu", OP_MULHSU, 32'hFFFFFFFF, 32'h2, mduExp(32'hFFFFFFFF), MDU_LAT);   checkOutput(0);
    applyStimulus("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, mduExp(32'h80000000), MDU_LAT); checkOutput(0);
    applyStimulus("rem_ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, MDU_LAT);            checkOutput(0);
    applyStimulus("divu_zero", OP_DIVU, 32'h7, 32'h0, mduExp(32'hFFFFFFFF), MDU_LAT);         checkOutput(0);
    applyStimulus("remu_zero", OP_REMU, 32'h7, 32'h0, mduExp(32'h7), MDU_LAT);                checkOutput(0);
    applyStimulus("div_zero_s", OP_DIV, 32'hFFFFFFF9, 32'h0, mduExp(32'hFFFFFFFF), MDU_LAT);  checkOutput(0);
    applyStimulus("rem_zero_s", OP_REM, 32'hFFFFFFF9, 32'h0, mduExp(32'hFFFFFFF9), MDU_LAT);  checkOutput(0);
    applyStimulus("div_neg", OP_DIV, 32'hFFFFFFF9, 32'h2, mduExp(32'hFFFFFFFD), MDU_LAT);     checkOutput(0);
    applyStimulus("rem_neg", OP_REM, 32'hFFFFFFF9, 32'h2, mduExp(32'hFFFFFFFF), MDU_LAT);     checkOutput(0);
    applyStimulus("divu", OP_DIVU, 32'd100, 32'd7, mduExp(32'd14), MDU_LAT);                  checkOutput(0);
    applyStimulus("remu", OP_REMU, 32'd100, 32'd7, mduExp(32'd2), MDU_LAT);                   checkOutput(0);

    applyStimulus("hold", OP_ADD, 32'h5, 32'h6, 32'hB, 1);
    checkOutput(5);
    @(negedge i_clk);
    checkValue("hold_no_extra_valid", 32'(bus.o_valid), 32'd0);

    // Reset and a request in the same cycle: reset wins, nothing is accepted.
    @(negedge i_clk);
    i_rst           = 1'b1;
    bus.i_valid     = 1'b1;
    bus.i_alu_op    = OP_ADD;
    bus.i_operand_a = 32'h1;
    bus.i_operand_b = 32'h1;
    @(posedge i_clk);
    #1;
    i_rst       = 1'b0;
    bus.i_valid = 1'b0;
    @(negedge i_clk);
    checkValue("rst_prio_ready", 32'(bus.o_ready), 32'd1);
    checkValue("rst_prio_valid", 32'(bus.o_valid), 32'd0);
    @(negedge i_clk);
    checkValue("rst_prio_no_result", 32'(bus.o_valid), 32'd0);

    // Reset while a result waits in DONE drops it.
    applyStimulus("done_abort", OP_ADD, 32'h9, 32'h9, 32'h12, 1);
    waited = 0;
    @(negedge i_clk);
    while (!bus.o_valid && waited < 50) begin
      @(negedge i_clk);
      waited++;
    end
    checkValue("done_abort_valid", 32'(bus.o_valid), 32'd1);
    sb.delete();
    i_rst = 1'b1;
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    checkValue("done_abort_rst_valid", 32'(bus.o_valid), 32'd0);
    checkValue("done_abort_rst_ready", 32'(bus.o_ready), 32'd1);
    checkValue("done_abort_rst_data", bus.o_alu_data, 32'h0);

`ifdef SEQ_ALU_MDU_EN
    // Reset during the 10th BUSY cycle of a multiply abandons it for good.
    applyStimulus("busy_abort", OP_MUL, 32'h3, 32'h4, 32'hC, MDU_LAT);
    repeat (9) @(posedge i_clk);
    #1 i_rst = 1'b1;
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    sb.delete();
    @(negedge i_clk);
    checkValue("busy_abort_valid", 32'(bus.o_valid), 32'd0);
    checkValue("busy_abort_ready", 32'(bus.o_ready), 32'd1);
    bus.i_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge i_clk);
      if (bus.o_valid) seen++;
    end
    bus.i_ready = 1'b0;
    checkValue("busy_abort_no_result", 32'(seen), 32'd0);
`else
    seen = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand/result width (even, >=8).
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), giving the shift-amount width.
REQ-003 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_valid  input  1  request valid.
REQ-006 o_ready  output  1  block can accept a request this cycle.
REQ-007 i_alu_op  input  5  operation code.
REQ-008 i_operand_a  input  WIDTH  operand A (rs1).
REQ-009 i_operand_b  input  WIDTH  operand B (rs2/imm).
REQ-010 o_valid  output  1  result valid.
REQ-011 i_ready  input  1  consumer accepts the result.
REQ-012 o_alu_data  output  WIDTH  registered result.

Function
REQ-013 Op codes SHALL be: 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 XOR, 5 OR, 6 AND, 7 SLL, 8 SRL, 9 SRA (base); 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU (MDU); all other codes are unsupported.
REQ-014 The FSM SHALL have states IDLE, BUSY, DONE; o_ready = 1 only in IDLE.
REQ-015 Acceptance SHALL occur at a rising edge in IDLE with i_valid=1; operands and op are latched then, and inputs are ignored outside IDLE.
REQ-016 Base and unsupported ops SHALL go IDLE->DONE; result valid in the cycle after acceptance (latency 1).
REQ-017 MDU ops SHALL go IDLE->BUSY, iterate radix-2 for exactly WIDTH cycles, then DONE; o_valid is first high WIDTH+1 cycles after acceptance (33 for WIDTH=32).
REQ-018 In DONE, o_valid=1 and o_alu_data SHALL be held stable until i_ready=1; that edge returns to IDLE (no new acceptance in the same cycle).
REQ-019 ADD/SUB SHALL wrap modulo 2^WIDTH; SLT/SLTU SHALL return zero-extended 1/0.
REQ-020 Shifts SHALL use i_operand_b[SHW-1:0]; SRA replicates bit WIDTH-1.
REQ-021 MUL SHALL return the low WIDTH bits; MULH/MULHSU/MULHU the high WIDTH bits of the 2*WIDTH-bit product, with signedness s*s, s*u, u*u respectively.
REQ-022 Division by zero SHALL yield quotient all-ones (DIV and DIVU) and remainder = dividend, at the normal MDU latency.
REQ-023 Signed overflow (most-negative / -1) SHALL yield quotient = most-negative, remainder = 0.
REQ-024 Signed DIV/REM SHALL truncate toward zero; the remainder takes the sign of the dividend.
REQ-025 Unsupported ops SHALL return 0.

Reset
REQ-026 While i_rst=1 at an edge, the FSM SHALL enter IDLE, with o_valid=0, o_alu_data=0, iteration counter=0 and internal accumulators cleared.
REQ-027 Reset in BUSY or DONE SHALL abandon the operation with no result; o_ready=1 in the first cycle after reset deasserts.
REQ-028 Reset SHALL take priority over i_valid and i_ready in the same cycle.

Configuration
REQ-029 Macro SEQ_ALU_MDU_EN defined: MDU ops SHALL behave as in REQ-017, REQ-021 to REQ-024.
REQ-030 Macro SEQ_ALU_MDU_EN undefined: the multiplier/divider datapath and BUSY state SHALL be absent, and op codes 16-23 SHALL be treated as unsupported (result 0, latency 1).

Verification
REQ-031 ADD a=0x7FFFFFFF, b=1, i_ready=1 -> o_valid at T+1, o_alu_data=0x80000000; SRA a=0x80000000, b=0x24 -> 0xF8000000.
REQ-032 DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 at T+33; REM with the same operands -> 0.
REQ-033 DIVU a=7, b=0 -> 0xFFFFFFFF; REMU a=7, b=0 -> 7; DIV a=-7, b=2 -> 0xFFFFFFFD; REM a=-7, b=2 -> 0xFFFFFFFF.
REQ-034 MULH a=b=0xFFFFFFFF -> 0; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
REQ-035 i_ready held low for 5 cycles in DONE -> o_valid and o_alu_data stable, o_ready=0, i_valid pulses ignored; then i_ready=1 -> IDLE next cycle.
REQ-036 i_rst pulsed in the 10th BUSY cycle of a MUL -> next cycle o_valid=0, o_ready=1, and no result is ever produced; with the macro undefined, MUL a=3, b=4 -> 0 at T+1.
